// File: rtl/wb_arbiter2_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter2_if
//  Purpose  : Bundles the two Wishbone master ports and the shared slave port.
//  Revision : 1.0  initial release
// ============================================================================
interface wb_arbiter2_if;
   logic [1:0]  m_cyc_i;
   logic [1:0]  m_stb_i;
   logic [1:0]  m_we_i;
   logic [63:0] m_adr_i;
   logic [63:0] m_dat_i;
   logic [7:0]  m_sel_i;
   logic [31:0] m_dat_o;
   logic [1:0]  m_ack_o;
   logic [1:0]  m_err_o;
   logic [1:0]  m_rty_o;
   logic        s_cyc_o;
   logic        s_stb_o;
   logic        s_we_o;
   logic [31:0] s_adr_o;
   logic [31:0] s_dat_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_dat_i;
   logic        s_ack_i;
   logic        s_err_i;
   logic        s_rty_i;
   logic [1:0]  grant_o;

   // master: the arbiter's view (it masters the slave bus); slave: the surrounding system
   modport master (
      input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
      input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
      output m_dat_o, m_ack_o, m_err_o, m_rty_o,
      output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      output grant_o
   );

   modport slave (
      output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
      output s_dat_i, s_ack_i, s_err_i, s_rty_i,
      input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      input  grant_o
   );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter2
//  Purpose  : Two-master Wishbone classic arbiter, round-robin, with watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module wb_arbiter2 #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_WIDTH  = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   wb_arbiter2_if.master bus
);

   localparam logic [0:0] c_st_idle    = 1'b0;
   localparam logic [0:0] c_st_granted = 1'b1;

   logic [0:0]               r_state;
   logic                     r_owner;
   logic                     r_last_owner;
   logic [TIMEOUT_WIDTH-1:0] r_wd_cnt;

   logic                     w_busy;
   logic                     w_own_cyc;
   logic                     w_own_stb;
   logic                     w_resp;
   logic                     w_stall;
   logic                     w_timeout;
   logic                     w_next_owner;
   logic [TIMEOUT_WIDTH-1:0] w_wd_next;

   assign w_busy    = (r_state == c_st_granted);
   assign w_own_cyc = bus.m_cyc_i[r_owner];
   assign w_own_stb = bus.m_stb_i[r_owner];
   assign w_resp    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
   assign w_stall   = w_busy & w_own_cyc & w_own_stb & ~w_resp;

   // On a tie the master that did not own the bus last wins
   always_comb begin
      w_next_owner = r_owner;
      case (bus.m_cyc_i)
         2'b01:   w_next_owner = 1'b0;
         2'b10:   w_next_owner = 1'b1;
         2'b11:   w_next_owner = ~r_last_owner;
         default: w_next_owner = r_owner;
      endcase
   end

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_wd_on
         localparam logic [TIMEOUT_WIDTH-1:0] c_wd_last = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

         assign w_timeout = w_stall & (r_wd_cnt == c_wd_last);

         always_comb begin
            w_wd_next = r_wd_cnt;
            if (!w_busy || !w_own_cyc || w_resp || w_timeout) begin
               w_wd_next = '0;
            end else if (w_stall && (r_wd_cnt != c_wd_last)) begin
               w_wd_next = r_wd_cnt + TIMEOUT_WIDTH'(1);
            end
         end
      end else begin : g_wd_off
         assign w_timeout = 1'b0;
         assign w_wd_next = '0;
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= c_st_idle;
         r_owner      <= 1'b0;
         r_last_owner <= 1'b1;
         r_wd_cnt     <= '0;
      end else begin
         r_wd_cnt <= w_wd_next;
         case (r_state)
            c_st_idle: begin
               if (bus.m_cyc_i != 2'b00) begin
                  r_state <= c_st_granted;
                  r_owner <= w_next_owner;
               end
            end
            c_st_granted: begin
               // Releasing always passes through idle, so owners never hand over directly
               if (!w_own_cyc) begin
                  r_state      <= c_st_idle;
                  r_last_owner <= r_owner;
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   always_comb begin
      bus.s_cyc_o = 1'b0;
      bus.s_stb_o = 1'b0;
      bus.s_we_o  = 1'b0;
      bus.s_adr_o = '0;
      bus.s_dat_o = '0;
      bus.s_sel_o = '0;
      bus.m_ack_o = 2'b00;
      bus.m_err_o = 2'b00;
      bus.m_rty_o = 2'b00;
      bus.grant_o = 2'b00;
      bus.m_dat_o = bus.s_dat_i;
      if (w_busy) begin
         bus.grant_o = r_owner ? 2'b10 : 2'b01;
         bus.s_cyc_o = w_own_cyc & ~w_timeout;
         bus.s_stb_o = w_own_cyc & w_own_stb & ~w_timeout;
         bus.s_we_o  = bus.m_we_i[r_owner];
         bus.s_adr_o = r_owner ? bus.m_adr_i[63:32] : bus.m_adr_i[31:0];
         bus.s_dat_o = r_owner ? bus.m_dat_i[63:32] : bus.m_dat_i[31:0];
         bus.s_sel_o = r_owner ? bus.m_sel_i[7:4]   : bus.m_sel_i[3:0];
         // An owner that has dropped cyc has abandoned the cycle; nothing is routed back
         if (w_own_cyc) begin
            bus.m_ack_o[r_owner] = bus.s_ack_i;
            bus.m_err_o[r_owner] = bus.s_err_i | w_timeout;
            bus.m_rty_o[r_owner] = bus.s_rty_i;
         end
      end
   end

endmodule
`default_nettype wire
